// File: rtl/riscv_cache_biu_ctrl.sv
// Cache-to-BIU responder: line fills become BIU bursts, non-cacheable reads become SINGLE reads.
// Define RV_CACHE_BIU_WRAP_EN for critical-word-first WRAP bursts; default is line-aligned INCR.
package riscv_cache_biu_pkg;
   typedef enum logic [1:0] {
      BIUCMD_NOP     = 2'd0,
      BIUCMD_READWAY = 2'd1
   } biucmd_t;

   typedef enum logic [2:0] {
      BYTE  = 3'd0,
      HWORD = 3'd1,
      WORD  = 3'd2,
      DWORD = 3'd3,
      QWORD = 3'd4
   } biu_size_t;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } biu_type_t;

   typedef logic [2:0] biu_prot_t;
endpackage

module riscv_cache_biu_ctrl
   import riscv_cache_biu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int PLEN           = (XLEN == 32) ? 34 : 56,
   parameter int PARCEL_SIZE    = XLEN,
   parameter int BLOCK_SIZE     = 32,
   parameter int INFLIGHT_DEPTH = 2,
   parameter int BIUTAG_SIZE    = (XLEN / PARCEL_SIZE > 1) ? $clog2(XLEN / PARCEL_SIZE) : 1
) (
   input  logic                                  rst_ni,
   input  logic                                  clk_i,

   input  biucmd_t                               biucmd_i,
   output logic                                  biucmd_ack_o,
   input  logic                                  biucmd_noncacheable_req_i,
   output logic                                  biucmd_noncacheable_ack_o,
   input  logic [PLEN-1:0]                       biucmd_adri_i,
   input  logic [BIUTAG_SIZE-1:0]                biucmd_tagi_i,
   input  biu_size_t                             size_i,
   input  logic                                  lock_i,
   input  biu_prot_t                             prot_i,
   input  logic [PLEN-1:0]                       req_adr_i,
   output logic [$clog2(INFLIGHT_DEPTH+1)-1:0]   inflight_cnt_o,
   output logic                                  biu_stb_ack_o,
   output logic                                  biu_ack_o,
   output logic                                  biu_err_o,
   output logic [XLEN-1:0]                       biu_q_o,
   output logic [PLEN-1:0]                       biu_adro_o,
   output logic [BIUTAG_SIZE-1:0]                biu_tago_o,
   output logic                                  in_biubuffer_o,
   output logic [8*BLOCK_SIZE-1:0]               biubuffer_o,

   output logic                                  mem_we_o,
   output logic [8*BLOCK_SIZE-1:0]               mem_line_o,

   output logic                                  biu_stb_o,
   input  logic                                  biu_stb_ack_i,
   output logic [PLEN-1:0]                       biu_adri_o,
   output biu_size_t                             biu_size_o,
   output biu_type_t                             biu_type_o,
   output logic                                  biu_lock_o,
   output biu_prot_t                             biu_prot_o,
   output logic                                  biu_we_o,
   input  logic [XLEN-1:0]                       biu_q_i,
   input  logic                                  biu_ack_i,
   input  logic                                  biu_err_i,
   input  logic [PLEN-1:0]                       biu_adro_i
);

   localparam int BLK_BITS = 8 * BLOCK_SIZE;
   localparam int BEATS    = BLK_BITS / XLEN;
   localparam int BEAT_W   = $clog2(BEATS);
   localparam int WOFF_LSB = $clog2(XLEN / 8);
   localparam int LINE_LSB = $clog2(BLOCK_SIZE);
   localparam int CNT_W    = $clog2(INFLIGHT_DEPTH + 1);
   localparam int PTR_W    = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;

   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(INFLIGHT_DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(INFLIGHT_DEPTH - 1);
   localparam biu_size_t         BURST_SIZE = (XLEN == 64) ? DWORD : WORD;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BURST_REQ  = 2'd1,
      BURST_DATA = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic                           pending_q;
   logic [PLEN-1:0]                fill_adr_q;
   logic [PLEN-1:0]                burst_adr;
   logic [BEAT_W-1:0]              beat_q;
   logic                           err_q;
   logic [BEATS-1:0]               valid_q;
   logic [BEATS-1:0][XLEN-1:0]     buf_q;
   logic [CNT_W-1:0]               cnt_q, cnt_nxt;
   logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
   logic [BIUTAG_SIZE-1:0]         tag_mem [INFLIGHT_DEPTH];

   logic                           fill_req, fill_start;
   logic                           nc_stb, cnt_inc, cnt_dec;
   logic [BEAT_W-1:0]              beat_widx, req_widx;
   logic                           unused_ok;

`ifdef RV_CACHE_BIU_WRAP_EN
   localparam biu_type_t BURST_TYPE = (BEATS == 4)  ? WRAP4  :
                                      (BEATS == 8)  ? WRAP8  :
                                      (BEATS == 16) ? WRAP16 : INCR;
   assign burst_adr = {fill_adr_q[PLEN-1:WOFF_LSB], {WOFF_LSB{1'b0}}};
`else
   localparam biu_type_t BURST_TYPE = (BEATS == 4)  ? INCR4  :
                                      (BEATS == 8)  ? INCR8  :
                                      (BEATS == 16) ? INCR16 : INCR;
   assign burst_adr = {fill_adr_q[PLEN-1:LINE_LSB], {LINE_LSB{1'b0}}};
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // A pending fill blocks new single reads so the outstanding count can drain to zero.
   assign fill_req   = (state_q == IDLE) & ((biucmd_i == BIUCMD_READWAY) | pending_q);
   assign nc_stb     = (state_q == IDLE) & biucmd_noncacheable_req_i & ~fill_req &
                       (cnt_q < DEPTH_C);
   assign cnt_inc    = nc_stb & biu_stb_ack_i;
   assign cnt_dec    = biu_ack_i & (cnt_q != '0);
   assign fill_start = fill_req & (cnt_nxt == '0);

   always_comb begin
      unique case ({cnt_inc, cnt_dec})
         2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
         2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
         default: cnt_nxt = cnt_q;
      endcase
   end

   assign beat_widx = biu_adro_i[WOFF_LSB +: BEAT_W];
   assign req_widx  = req_adr_i[WOFF_LSB +: BEAT_W];

   // NOTE: every output of this block gets a default before the case, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      biu_stb_o    = 1'b0;
      biu_adri_o   = '0;
      biu_size_o   = BYTE;
      biu_type_o   = SINGLE;
      biu_lock_o   = 1'b0;
      biu_prot_o   = '0;
      biucmd_ack_o = 1'b0;
      mem_we_o     = 1'b0;

      if (nc_stb) begin
         biu_stb_o  = 1'b1;
         biu_adri_o = biucmd_adri_i;
         biu_size_o = size_i;
         biu_lock_o = lock_i;
         biu_prot_o = prot_i;
      end

      unique case (state_q)
         IDLE: begin
            if (fill_start) state_d = BURST_REQ;
         end
         BURST_REQ: begin
            biu_stb_o  = 1'b1;
            biu_adri_o = burst_adr;
            biu_size_o = BURST_SIZE;
            biu_type_o = BURST_TYPE;
            biu_lock_o = lock_i;
            biu_prot_o = prot_i;
            if (biu_stb_ack_i) state_d = BURST_DATA;
         end
         BURST_DATA: begin
            if (biu_ack_i && (biu_err_i || beat_q == LAST_BEAT)) state_d = DONE;
         end
         DONE: begin
            biucmd_ack_o = 1'b1;
            mem_we_o     = ~err_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is assigned with non-blocking <= so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         fill_adr_q <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         valid_q    <= '0;
         buf_q      <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_nxt;

         if (state_q == IDLE) begin
            pending_q <= fill_req & ~fill_start;
            if (biucmd_i == BIUCMD_READWAY && !pending_q) fill_adr_q <= biucmd_adri_i;
            if (fill_start) begin
               valid_q <= '0;
               beat_q  <= '0;
               err_q   <= 1'b0;
            end
         end

         // Beats land by their returned address, so WRAP and INCR orders build the same line.
         if (state_q == BURST_DATA && biu_ack_i) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (biu_err_i) begin
               err_q <= 1'b1;
            end else begin
               buf_q[beat_widx]   <= biu_q_i;
               valid_q[beat_widx] <= 1'b1;
            end
         end

         if (cnt_inc) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (cnt_dec) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   // NOTE: tag storage has no reset; only the pointers and count do, and an entry is never
   // read before it has been written.
   always_ff @(posedge clk_i) begin
      if (cnt_inc) tag_mem[wr_ptr_q] <= biucmd_tagi_i;
   end

   assign inflight_cnt_o            = cnt_q;
   assign biu_stb_ack_o             = cnt_inc;
   assign biucmd_noncacheable_ack_o = cnt_dec;

   assign biu_ack_o  = biu_ack_i;
   assign biu_err_o  = biu_err_i;
   assign biu_q_o    = biu_q_i;
   assign biu_adro_o = biu_adro_i;
   assign biu_tago_o = (cnt_q != '0) ? tag_mem[rd_ptr_q] : biu_adro_i[1 +: BIUTAG_SIZE];
   assign biu_we_o   = 1'b0;

   assign in_biubuffer_o = (state_q != IDLE) &
                           (req_adr_i[PLEN-1:LINE_LSB] == fill_adr_q[PLEN-1:LINE_LSB]) &
                           valid_q[req_widx];
   assign biubuffer_o = buf_q;
   assign mem_line_o  = buf_q;

   assign unused_ok = ^{req_adr_i[WOFF_LSB-1:0], fill_adr_q[LINE_LSB-1:0]};

endmodule

// File: tb/tb_riscv_cache_biu_ctrl.sv
// Self-checking bench for riscv_cache_biu_ctrl: directed fills, single reads and reset,
// with randomized data/tags checked against a queue-and-array reference model.
module tb_riscv_cache_biu_ctrl;
   import riscv_cache_biu_pkg::*;

   localparam int XLEN       = 32;
   localparam int PLEN       = 34;
   localparam int BLOCK_SIZE = 32;
   localparam int BLK_BITS   = 8 * BLOCK_SIZE;
   localparam int BEATS      = BLK_BITS / XLEN;
   localparam int DEPTH      = 2;
   localparam int TW         = 1;
   localparam int CW         = $clog2(DEPTH + 1);

`ifdef RV_CACHE_BIU_WRAP_EN
   localparam bit        WRAP_MODE = 1'b1;
   localparam biu_type_t EXP_BURST = WRAP8;
`else
   localparam bit        WRAP_MODE = 1'b0;
   localparam biu_type_t EXP_BURST = INCR8;
`endif

   logic                rst_ni, clk_i;
   biucmd_t             biucmd_i;
   logic                biucmd_ack_o, biucmd_noncacheable_req_i, biucmd_noncacheable_ack_o;
   logic [PLEN-1:0]     biucmd_adri_i, req_adr_i, biu_adro_o, biu_adri_o, biu_adro_i;
   logic [TW-1:0]       biucmd_tagi_i, biu_tago_o;
   biu_size_t           size_i, biu_size_o;
   logic                lock_i, biu_lock_o;
   biu_prot_t           prot_i, biu_prot_o;
   logic [CW-1:0]       inflight_cnt_o;
   logic                biu_stb_ack_o, biu_ack_o, biu_err_o, in_biubuffer_o;
   logic [XLEN-1:0]     biu_q_o, biu_q_i;
   logic [BLK_BITS-1:0] biubuffer_o, mem_line_o;
   logic                mem_we_o, biu_stb_o, biu_stb_ack_i, biu_we_o;
   biu_type_t           biu_type_o;
   logic                biu_ack_i, biu_err_i;

   riscv_cache_biu_ctrl #(
      .XLEN(XLEN), .PLEN(PLEN), .PARCEL_SIZE(XLEN), .BLOCK_SIZE(BLOCK_SIZE),
      .INFLIGHT_DEPTH(DEPTH), .BIUTAG_SIZE(TW)
   ) dut (
      .rst_ni(rst_ni), .clk_i(clk_i),
      .biucmd_i(biucmd_i), .biucmd_ack_o(biucmd_ack_o),
      .biucmd_noncacheable_req_i(biucmd_noncacheable_req_i),
      .biucmd_noncacheable_ack_o(biucmd_noncacheable_ack_o),
      .biucmd_adri_i(biucmd_adri_i), .biucmd_tagi_i(biucmd_tagi_i),
      .size_i(size_i), .lock_i(lock_i), .prot_i(prot_i), .req_adr_i(req_adr_i),
      .inflight_cnt_o(inflight_cnt_o), .biu_stb_ack_o(biu_stb_ack_o),
      .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o), .biu_q_o(biu_q_o),
      .biu_adro_o(biu_adro_o), .biu_tago_o(biu_tago_o),
      .in_biubuffer_o(in_biubuffer_o), .biubuffer_o(biubuffer_o),
      .mem_we_o(mem_we_o), .mem_line_o(mem_line_o),
      .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_adri_o(biu_adri_o),
      .biu_size_o(biu_size_o), .biu_type_o(biu_type_o), .biu_lock_o(biu_lock_o),
      .biu_prot_o(biu_prot_o), .biu_we_o(biu_we_o), .biu_q_i(biu_q_i),
      .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i), .biu_adro_i(biu_adro_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: line contents by word, valid words, outstanding tags in issue order.
   logic [XLEN-1:0] exp_word [BEATS];
   bit              exp_valid[BEATS];
   logic [TW-1:0]   tag_q[$];

   task automatic check(input string tag, input logic [BLK_BITS-1:0] obs,
                        input logic [BLK_BITS-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      biucmd_i = BIUCMD_NOP;   biucmd_noncacheable_req_i = 1'b0;
      biucmd_adri_i = '0;      biucmd_tagi_i = '0;
      size_i = BYTE;           lock_i = 1'b0;   prot_i = '0;
      biu_stb_ack_i = 1'b0;    biu_q_i = '0;    biu_ack_i = 1'b0;
      biu_err_i = 1'b0;        biu_adro_i = '0;
   endtask

   function automatic logic [BLK_BITS-1:0] exp_line();
      logic [BLK_BITS-1:0] l;
      for (int i = 0; i < BEATS; i++) l[i*XLEN +: XLEN] = exp_word[i];
      return l;
   endfunction

   task automatic issue_readway(input logic [PLEN-1:0] adr);
      biucmd_i = BIUCMD_READWAY;
      biucmd_adri_i = adr;
      req_adr_i = adr;
      #1;
      check("stb_before_fill", biu_stb_o, 1'b0);
      tick();
      biucmd_i = BIUCMD_NOP;
   endtask

   // Entered in the cycle the burst strobe should be visible; err_beat >= BEATS means no error.
   task automatic run_fill(input logic [PLEN-1:0] adr, input int err_beat);
      logic [PLEN-1:0] base, a, exp_adr;
      logic [XLEN-1:0] q;
      biu_prot_t       pr;
      int              start_w, w, rw;
      bit              err_seen;
      err_seen = 1'b0;
      base     = adr & ~PLEN'(BLOCK_SIZE - 1);
      exp_adr  = WRAP_MODE ? (adr & ~PLEN'(XLEN/8 - 1)) : base;
      start_w  = WRAP_MODE ? int'(adr[4:2]) : 0;
      rw       = int'(adr[4:2]);
      for (int i = 0; i < BEATS; i++) exp_valid[i] = 1'b0;

      pr = biu_prot_t'($urandom_range(0, 7));
      lock_i = 1'b1; prot_i = pr; biu_stb_ack_i = 1'b1;
      #1;
      check("burst_stb",  biu_stb_o, 1'b1);
      check("burst_adri", biu_adri_o, exp_adr);
      check("burst_type", biu_type_o, EXP_BURST);
      check("burst_size", biu_size_o, WORD);
      check("burst_lock", biu_lock_o, 1'b1);
      check("burst_prot", biu_prot_o, pr);
      tick();
      biu_stb_ack_i = 1'b0; lock_i = 1'b0; prot_i = '0;
      biucmd_noncacheable_req_i = 1'b1;

      for (int b = 0; b < BEATS; b++) begin
         w = (start_w + b) % BEATS;
         a = base + PLEN'(w * (XLEN/8));
         q = $urandom;
         biu_ack_i = 1'b1; biu_adro_i = a; biu_q_i = q; biu_err_i = (b == err_beat);
         #1;
         check("stb_during_burst", biu_stb_o, 1'b0);
         check("beat_ack_pass", biu_ack_o, 1'b1);
         check("beat_q_pass",   biu_q_o, q);
         check("beat_err_pass", biu_err_o, (b == err_beat));
         check("beat_adro_pass", biu_adro_o, a);
         check("beat_tago",     biu_tago_o, a[1]);
         if (b == err_beat) err_seen = 1'b1;
         else begin
            exp_word[w]  = q;
            exp_valid[w] = 1'b1;
         end
         tick();
         check("in_biubuffer", in_biubuffer_o, exp_valid[rw]);
         if (err_seen) break;
      end

      biu_ack_i = 1'b0; biu_err_i = 1'b0; biucmd_noncacheable_req_i = 1'b0;
      #1;
      check("fill_ack",  biucmd_ack_o, 1'b1);
      check("fill_we",   mem_we_o, !err_seen);
      if (!err_seen) begin
         check("fill_line", mem_line_o, exp_line());
         req_adr_i = adr ^ PLEN'(BLOCK_SIZE);
         #1;
         check("in_biubuffer_other_line", in_biubuffer_o, 1'b0);
         req_adr_i = adr;
      end
      tick();
      check("fill_ack_end", biucmd_ack_o, 1'b0);
      check("fill_we_end",  mem_we_o, 1'b0);
      check("in_biubuffer_idle", in_biubuffer_o, 1'b0);
   endtask

   // One IDLE cycle of single-read traffic, checked against the tag queue.
   task automatic nc_cycle(input bit req, input logic [TW-1:0] t, input bit sack, input bit ack);
      logic [PLEN-1:0] a;
      biu_size_t       sz;
      bit              e_stb, e_sack, e_ack, lk;
      biu_prot_t       pr;
      a  = PLEN'($urandom) << 2;
      sz = biu_size_t'($urandom_range(0, 2));
      lk = 1'($urandom);
      pr = biu_prot_t'($urandom_range(0, 7));
      biucmd_noncacheable_req_i = req; biucmd_adri_i = a; biucmd_tagi_i = t;
      size_i = sz; lock_i = lk; prot_i = pr;
      biu_stb_ack_i = sack; biu_ack_i = ack; biu_q_i = $urandom;
      e_stb  = req && (tag_q.size() < DEPTH);
      e_sack = e_stb && sack;
      e_ack  = ack && (tag_q.size() > 0);
      #1;
      check("nc_stb",     biu_stb_o, e_stb);
      check("nc_stb_ack", biu_stb_ack_o, e_sack);
      check("nc_ack",     biucmd_noncacheable_ack_o, e_ack);
      if (e_stb) begin
         check("nc_adri", biu_adri_o, a);
         check("nc_size", biu_size_o, sz);
         check("nc_type", biu_type_o, SINGLE);
         check("nc_lock", biu_lock_o, lk);
         check("nc_prot", biu_prot_o, pr);
      end
      if (e_ack) check("nc_tago", biu_tago_o, tag_q[0]);
      tick();
      if (e_ack) void'(tag_q.pop_front());
      if (e_sack) tag_q.push_back(t);
      check("inflight_cnt", inflight_cnt_o, tag_q.size());
      idle_inputs();
   endtask

   initial begin
      logic [PLEN-1:0] adr;
      rst_ni = 1'b0;
      req_adr_i = '0;
      idle_inputs();
      tick();
      tick();
      check("rst_stb",       biu_stb_o, 1'b0);
      check("rst_cmd_ack",   biucmd_ack_o, 1'b0);
      check("rst_we",        mem_we_o, 1'b0);
      check("rst_inflight",  inflight_cnt_o, 0);
      check("rst_in_buf",    in_biubuffer_o, 1'b0);
      check("rst_buffer",    biubuffer_o, '0);
      check("rst_we_tie",    biu_we_o, 1'b0);
      check("rst_tago",      biu_tago_o, 0);
      rst_ni = 1'b1;
      tick();

      // Test-plan fill at 0x100C
      issue_readway(PLEN'('h100C));
      run_fill(PLEN'('h100C), BEATS);

      // Two accepted single reads, a refused third, in-order tag return
      nc_cycle(1'b1, 1'b1, 1'b1, 1'b0);
      nc_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      nc_cycle(1'b1, 1'b1, 1'b1, 1'b0);
      nc_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nc_cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Simultaneous push and pop keeps the count
      nc_cycle(1'b1, 1'b1, 1'b1, 1'b0);
      nc_cycle(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++)
         nc_cycle(1'($urandom), TW'($urandom), 1'($urandom),
                  (tag_q.size() > 0) && 1'($urandom));
      for (int i = 0; i < DEPTH + 2 && tag_q.size() > 0; i++)
         nc_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("drained", inflight_cnt_o, 0);

      // READWAY held pending behind an outstanding single read
      nc_cycle(1'b1, TW'($urandom), 1'b1, 1'b0);
      adr = (PLEN'($urandom) << 2);
      biucmd_i = BIUCMD_READWAY; biucmd_adri_i = adr; req_adr_i = adr;
      #1;
      check("pending_no_stb", biu_stb_o, 1'b0);
      tick();
      biucmd_i = BIUCMD_NOP;
      for (int i = 0; i < 3; i++) nc_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      nc_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      run_fill(adr, BEATS);

      // Bus error on the third beat
      adr = (PLEN'($urandom) << 2);
      issue_readway(adr);
      run_fill(adr, 2);

      // Reset in the middle of a burst, then a clean fill
      adr = (PLEN'($urandom) << 2);
      issue_readway(adr);
      biu_stb_ack_i = 1'b1;
      tick();
      biu_stb_ack_i = 1'b0;
      for (int b = 0; b < 3; b++) begin
         biu_ack_i = 1'b1; biu_q_i = $urandom;
         biu_adro_i = (adr & ~PLEN'(BLOCK_SIZE - 1)) + PLEN'(b * 4);
         tick();
      end
      idle_inputs();
      rst_ni = 1'b0;
      #1;
      check("midrst_stb",      biu_stb_o, 1'b0);
      check("midrst_cmd_ack",  biucmd_ack_o, 1'b0);
      check("midrst_we",       mem_we_o, 1'b0);
      check("midrst_in_buf",   in_biubuffer_o, 1'b0);
      check("midrst_buffer",   biubuffer_o, '0);
      check("midrst_inflight", inflight_cnt_o, 0);
      #2;
      rst_ni = 1'b1;
      tick();
      issue_readway(adr);
      run_fill(adr, BEATS);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
